// File: rtl/aib_train_pkg.sv
// Shared types and helpers for the AIB receive delay-tap training sequencer.
package aib_train_pkg;

  localparam int unsigned TapW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_TAP,
    ST_SETTLE,
    ST_CHECK,
    ST_EVAL,
    ST_COMMIT,
    ST_DONE
  } train_state_e;

  // Midpoint of a window, summed one bit wider so 255+255 cannot wrap.
  function automatic logic [TapW-1:0] tap_centre(input logic [TapW-1:0] lo,
                                                 input logic [TapW-1:0] hi);
    logic [TapW:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[TapW:1];
  endfunction

endpackage

// File: rtl/aib_train_win.sv
// Single-lane passing-window tracker: records the first contiguous run of
// passing taps and reports its width check and centre.
module aib_train_win
  import aib_train_pkg::*;
#(
  parameter int unsigned MinWindow = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic            pass,
  input  logic            clr,
  input  logic [TapW-1:0] tap,
  output logic            in_window,
  output logic            width_ok_c,
  output logic [TapW-1:0] centre_c
);

  localparam int unsigned WidthW = TapW + 1;

  logic [TapW-1:0]   win_start;
  logic [TapW-1:0]   win_end;
  logic [WidthW-1:0] width_c;

  // Open on the first pass, extend on each further pass; a fail is handled by the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_window <= 1'b0;
      win_start <= '0;
      win_end   <= '0;
    end else if (clr) begin
      in_window <= 1'b0;
      win_start <= '0;
      win_end   <= '0;
    end else if (valid && pass) begin
      if (!in_window) begin
        in_window <= 1'b1;
        win_start <= tap;
      end
      win_end <= tap;
    end
  end

  always_comb begin
    width_c    = {1'b0, win_end} - {1'b0, win_start} + WidthW'(1);
    width_ok_c = in_window && (width_c >= WidthW'(MinWindow));
    centre_c   = tap_centre(win_start, win_end);
  end

endmodule

// File: rtl/aib_rx_dly_train.sv
// Receive delay-tap training sequencer: sweeps each lane's rx delay tap in turn
// and commits the centre of the first passing window found against a static pattern.
module aib_rx_dly_train
  import aib_train_pkg::*;
#(
  parameter int unsigned     NumIo        = 1,
  parameter int unsigned     SettleCycles = 4,
  parameter int unsigned     CheckCycles  = 8,
  parameter logic [TapW-1:0] MaxTap       = 8'd255,
  parameter int unsigned     MinWindow    = 4,
  parameter logic [TapW-1:0] DefaultTap   = 8'd64,
  parameter logic            ExpData0     = 1'b1,
  parameter logic            ExpData1     = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [NumIo-1:0]           i_rx_data0,
  input  logic [NumIo-1:0]           i_rx_data1,
  output logic [NumIo-1:0][TapW-1:0] o_rx_dly_tap,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_fail,
  output logic [NumIo-1:0]           o_lane_pass
);

  localparam int unsigned LaneW = (NumIo > 1) ? $clog2(NumIo) : 1;
  localparam int unsigned CntW  = 16;

  train_state_e               state;
  logic [LaneW-1:0]           lane;
  logic [TapW-1:0]            tap;
  logic [CntW-1:0]            cnt;
  logic                       tap_ok;
  logic [NumIo-1:0][TapW-1:0] saved;

  logic            lane_match_c;
  logic            eval_c;
  logic            commit_c;
  logic            in_window;
  logic            width_ok_c;
  logic [TapW-1:0] centre_c;

  always_comb begin
    lane_match_c = (i_rx_data0[lane] == ExpData0) && (i_rx_data1[lane] == ExpData1);
    eval_c       = (state == ST_EVAL);
    commit_c     = (state == ST_COMMIT);
  end

  aib_train_win #(
    .MinWindow (MinWindow)
  ) u_win (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .valid      (eval_c),
    .pass       (tap_ok),
    .clr        (commit_c),
    .tap        (tap),
    .in_window  (in_window),
    .width_ok_c (width_ok_c),
    .centre_c   (centre_c)
  );

  // Sequencer: one lane at a time, each tap costs SET_TAP + settle + check + EVAL.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      lane         <= '0;
      tap          <= '0;
      cnt          <= '0;
      tap_ok       <= 1'b0;
      saved        <= '0;
      o_rx_dly_tap <= {NumIo{DefaultTap}};
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_fail       <= 1'b0;
      o_lane_pass  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            lane        <= '0;
            tap         <= '0;
            o_fail      <= 1'b0;
            o_lane_pass <= '0;
            saved       <= o_rx_dly_tap;
            o_busy      <= 1'b1;
            state       <= ST_SET_TAP;
          end
        end
        ST_SET_TAP: begin
          o_rx_dly_tap[lane] <= tap;
          cnt                <= CntW'(SettleCycles - 1);
          state              <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            cnt    <= CntW'(CheckCycles - 1);
            tap_ok <= 1'b1;
            state  <= ST_CHECK;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        ST_CHECK: begin
          tap_ok <= tap_ok & lane_match_c;
          if (cnt == '0) begin
            state <= ST_EVAL;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        ST_EVAL: begin
          // A fail after the window opened ends the sweep: later windows are never used.
          if ((!tap_ok && in_window) || (tap == MaxTap)) begin
            state <= ST_COMMIT;
          end else begin
            tap   <= tap + TapW'(1);
            state <= ST_SET_TAP;
          end
        end
        ST_COMMIT: begin
          if (width_ok_c) begin
            o_rx_dly_tap[lane] <= centre_c;
            o_lane_pass[lane]  <= 1'b1;
          end else begin
            o_rx_dly_tap[lane] <= saved[lane];
            o_fail             <= 1'b1;
          end
          if (lane == LaneW'(NumIo - 1)) begin
            o_done <= 1'b1;
            state  <= ST_DONE;
          end else begin
            lane  <= lane + LaneW'(1);
            tap   <= '0;
            state <= ST_SET_TAP;
          end
        end
        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aib_rx_dly_train.sv
// Randomized bench for aib_rx_dly_train: a channel model answers each tap from a
// per-lane pass map, and a window-scan model predicts taps, flags and run length.
module tb_aib_rx_dly_train;

  localparam int unsigned NumIo   = 2;
  localparam int          TapCost = 14;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [NumIo-1:0]      rx_d0;
  logic [NumIo-1:0]      rx_d1;
  logic [NumIo-1:0][7:0] tap;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [NumIo-1:0]      lane_pass;

  always #5 clk = ~clk;

  aib_rx_dly_train #(
    .NumIo (NumIo)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_rx_data0   (rx_d0),
    .i_rx_data1   (rx_d1),
    .o_rx_dly_tap (tap),
    .o_busy       (busy),
    .o_done       (done),
    .o_fail       (fail),
    .o_lane_pass  (lane_pass)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  bit pmap [NumIo][256];
  int inj_tap = -1;
  int exp_tap [NumIo];

  logic [7:0] prev [NumIo];
  int age [NumIo];
  int cyc_ctr = 0;
  int done_cnt = 0;
  int t1 = -1;
  int t2 = -1;
  int l1_at_t1 = -1;

  // Channel: garbage while a new tap settles, then pattern or a wrong pair from the pass map.
  always @(negedge clk) begin
    cyc_ctr++;
    if (done) done_cnt++;
    for (int l = 0; l < NumIo; l++) begin
      if (tap[l] !== prev[l]) begin
        age[l] = 0;
        if (l == 0 && tap[0] == 8'd1 && t1 < 0) begin
          t1 = cyc_ctr;
          l1_at_t1 = int'(tap[1]);
        end
        if (l == 0 && tap[0] == 8'd2 && t2 < 0) t2 = cyc_ctr;
      end else if (age[l] < 100000) begin
        age[l]++;
      end
      prev[l] = tap[l];
      if (age[l] < 4) begin
        rx_d0[l] = 1'($urandom);
        rx_d1[l] = 1'($urandom);
      end else if (pmap[l][tap[l]] && !(l == 0 && int'(tap[l]) == inj_tap && age[l] == 8)) begin
        rx_d0[l] = 1'b1;
        rx_d1[l] = 1'b0;
      end else begin
        case ($urandom_range(0, 2))
          0:       begin rx_d0[l] = 1'b0; rx_d1[l] = 1'b0; end
          1:       begin rx_d0[l] = 1'b1; rx_d1[l] = 1'b1; end
          default: begin rx_d0[l] = 1'b0; rx_d1[l] = 1'b1; end
        endcase
      end
    end
  end

  // Reference: scan taps upward for the first window; the sweep ends one tap past it.
  function automatic void model_lane(input int l, output bit ok, output int ntap, output int newtap);
    int s;
    int e;
    bit p;
    s = -1;
    e = -1;
    ntap = 256;
    for (int t = 0; t < 256; t++) begin
      p = pmap[l][t] && !(l == 0 && t == inj_tap);
      if (p) begin
        if (s < 0) s = t;
        e = t;
      end else if (s >= 0) begin
        ntap = t + 1;
        break;
      end
    end
    ok = (s >= 0) && (e - s + 1 >= 4);
    newtap = ok ? (s + e) / 2 : exp_tap[l];
  endfunction

  task automatic clear_maps();
    for (int l = 0; l < NumIo; l++)
      for (int t = 0; t < 256; t++) pmap[l][t] = 1'b0;
    inj_tap = -1;
  endtask

  task automatic set_win(input int l, input int lo, input int hi);
    for (int t = lo; t <= hi && t < 256; t++) pmap[l][t] = 1'b1;
  endtask

  function automatic int lane0_taps();
    bit ok;
    int nt;
    int nw;
    model_lane(0, ok, nt, nw);
    return nt;
  endfunction

  task automatic run_train(input string name, input int repulse_at, input int rst_at);
    bit ok [NumIo];
    int nt [NumIo];
    int nw [NumIo];
    int total;
    int exp_cycles;
    int cyc;
    int d0;
    bit all_ok;
    total = 0;
    all_ok = 1'b1;
    for (int l = 0; l < NumIo; l++) begin
      model_lane(l, ok[l], nt[l], nw[l]);
      total += nt[l];
      all_ok &= ok[l];
    end
    exp_cycles = TapCost * total + NumIo + 1;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    check_eq({name, "_busy_start"}, 32'(busy), 32'd1);
    while (!done && cyc < exp_cycles + 50) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == repulse_at);
      if (cyc == rst_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int l = 0; l < NumIo; l++) check_eq({name, "_rst_tap"}, 32'(tap[l]), 32'd64);
        check_eq({name, "_rst_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_eq({name, "_rst_done"}, 32'(done), 32'd0);
        check_eq({name, "_rst_pass"}, 32'(lane_pass), 32'd0);
        check_eq({name, "_rst_tap0_held"}, 32'(tap[0]), 32'd64);
        rst_n = 1'b1;
        for (int l = 0; l < NumIo; l++) exp_tap[l] = 64;
        return;
      end
    end
    start = 1'b0;
    check_eq({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    check_eq({name, "_done"}, 32'(done), 32'd1);
    check_eq({name, "_busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check_eq({name, "_done_low"}, 32'(done), 32'd0);
    check_eq({name, "_busy_low"}, 32'(busy), 32'd0);
    for (int l = 0; l < NumIo; l++) begin
      check_eq({name, "_tap"}, 32'(tap[l]), 32'(nw[l]));
      exp_tap[l] = nw[l];
    end
    check_eq({name, "_lane_pass"}, 32'(lane_pass), 32'({ok[1], ok[0]}));
    check_eq({name, "_fail"}, 32'(fail), 32'(!all_ok));
    check_eq({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  int pre_l1;
  int lo;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    rx_d0 = '0;
    rx_d1 = '0;
    for (int l = 0; l < NumIo; l++) begin
      exp_tap[l] = 64;
      prev[l] = 8'd64;
      age[l] = 0;
    end
    clear_maps();
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < NumIo; l++) check_eq("reset_tap", 32'(tap[l]), 32'd64);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_fail", 32'(fail), 32'd0);
    check_eq("reset_pass", 32'(lane_pass), 32'd0);
    rst_n = 1'b1;

    // Lane 0 never passes; lane 1 still trains.
    clear_maps();
    set_win(1, 130, 140);
    run_train("nopass", -1, -1);

    // Nominal windows with a start re-pulse mid-run; also tap-step spacing.
    clear_maps();
    set_win(0, 40, 60);
    set_win(1, 200, 255);
    t1 = -1;
    t2 = -1;
    pre_l1 = exp_tap[1];
    run_train("nominal", 500, -1);
    check_eq("tap_step_spacing", 32'(t2 - t1), 32'(TapCost));
    check_eq("lane1_held", 32'(l1_at_t1), 32'(pre_l1));

    // Narrow first window; the wider second one must never be reached.
    clear_maps();
    set_win(0, 10, 12);
    set_win(0, 100, 120);
    lo = int'($urandom_range(0, 200));
    set_win(1, lo, lo + int'($urandom_range(0, 15)));
    run_train("narrow", -1, -1);

    // Single mismatch in the 5th compare cycle of tap 45.
    clear_maps();
    set_win(0, 40, 60);
    inj_tap = 45;
    lo = int'($urandom_range(0, 200));
    set_win(1, lo, lo + int'($urandom_range(0, 15)));
    run_train("inject", -1, -1);

    // Reset during lane 1 settle, then a fresh run.
    clear_maps();
    set_win(0, 40, 60);
    set_win(1, 200, 255);
    run_train("midreset", -1, TapCost * lane0_taps() + 4);
    run_train("retrain", -1, -1);

    // Boundaries: width-1 windows at tap 0 and at MaxTap.
    clear_maps();
    set_win(0, 0, 0);
    set_win(1, 255, 255);
    run_train("edge_w1", -1, -1);

    // Boundaries: exact minimum width at tap 0, window closing at MaxTap.
    clear_maps();
    set_win(0, 0, 3);
    set_win(1, 252, 255);
    run_train("edge_w4", -1, -1);

    for (int r = 0; r < 3; r++) begin
      clear_maps();
      for (int l = 0; l < NumIo; l++) begin
        lo = int'($urandom_range(0, 150));
        set_win(l, lo, lo + int'($urandom_range(0, 12)));
      end
      run_train("random", -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
